// File: rtl/inst_sequencer.sv
// inst_sequencer
//   Fetches 32-bit instructions from a synchronous instruction memory,
//   executes HALT / NOP / REPEAT itself, and hands the execution opcodes
//   (3..10) to the NU array. Nested REPEATs use a small hardware loop stack.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           begin at start_addr (accepted only in IDLE or ERROR)
//   start_addr      first instruction address
//   inst_rd_en      instruction memory read strobe (FETCH)
//   inst_addr       instruction memory address (= pc)
//   inst_rdata      read data, valid the cycle after inst_rd_en
//   issue_valid     execution instruction offered to the NU array
//   issue_ready     NU array accepts the offered instruction
//   issue_opcode    opcode of the offered instruction
//   issue_operands  remaining instruction bits
//   busy            high in FETCH, DECODE, ISSUE
//   done            one-cycle pulse after a HALT is decoded
//   error           high while in ERROR
//   loop_level      loop stack occupancy
//   state_dbg       current FSM state (debug visibility)
//
// Handshake: an instruction transfers on a rising clk edge where
// issue_valid && issue_ready. While issue_valid is high and issue_ready is
// low, issue_opcode/issue_operands hold their values; issue_valid never
// drops without a transfer except on reset.

module inst_sequencer #(
    parameter int INST_W     = 32,
    parameter int ADDR_W     = 6,
    parameter int OP_W       = 5,
    parameter int LOOP_DEPTH = 4,
    parameter int CNT_W      = 16,
    parameter int LEN_W      = 6,
    localparam int LVL_W     = $clog2(LOOP_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      start_addr,
    output logic                   inst_rd_en,
    output logic [ADDR_W-1:0]      inst_addr,
    input  logic [INST_W-1:0]      inst_rdata,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [OP_W-1:0]        issue_opcode,
    output logic [INST_W-OP_W-1:0] issue_operands,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [LVL_W-1:0]       loop_level,
    output logic [2:0]             state_dbg
);

    localparam int IDX_W = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_REPEAT = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LAST   = OP_W'(10);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0]      pc, pc_d;
    logic [LVL_W-1:0]       sp;
    logic [ADDR_W-1:0]      stk_start [LOOP_DEPTH];
    logic [ADDR_W-1:0]      stk_end   [LOOP_DEPTH];
    logic [CNT_W-1:0]       stk_rem   [LOOP_DEPTH];
    logic [OP_W-1:0]        op_q;
    logic [INST_W-OP_W-1:0] operands_q;
    logic                   done_q;

    // Decode fields
    logic [OP_W-1:0]  op_in;
    logic [CNT_W-1:0] rep_n;
    logic [LEN_W-1:0] rep_l;
    logic [SUM_W-1:0] sum;
    logic             ovf;

    assign op_in = inst_rdata[INST_W-1 -: OP_W];
    assign rep_n = inst_rdata[CNT_W-1:0];
    assign rep_l = inst_rdata[CNT_W+LEN_W-1:CNT_W];
    assign sum   = SUM_W'(pc) + SUM_W'(rep_l);
    // Body end must still be a legal address
    assign ovf   = (sum[SUM_W-1:ADDR_W] != '0);

    // Stack top view
    logic [IDX_W-1:0]  top_idx, push_idx;
    logic              stk_empty, stk_full;
    logic [ADDR_W-1:0] top_start, top_end;
    logic [CNT_W-1:0]  top_rem;

    assign top_idx   = IDX_W'(sp - 1'b1);
    assign push_idx  = IDX_W'(sp);
    assign stk_empty = (sp == '0);
    assign stk_full  = (sp == LVL_W'(LOOP_DEPTH));
    assign top_start = stk_start[top_idx];
    assign top_end   = stk_end[top_idx];
    assign top_rem   = stk_rem[top_idx];

    // Control
    logic              push_en, pop_en, dec_en, clr_en, latch_en, done_d;
    logic              adv_en;
    logic [ADDR_W-1:0] adv_a;

    always_comb begin
        state_d  = state;
        pc_d     = pc;
        push_en  = 1'b0;
        pop_en   = 1'b0;
        dec_en   = 1'b0;
        clr_en   = 1'b0;
        latch_en = 1'b0;
        done_d   = 1'b0;
        adv_en   = 1'b0;
        adv_a    = pc;

        case (state)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = start_addr;
                    clr_en  = 1'b1;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (op_in == OP_HALT) begin
                    done_d  = 1'b1;
                    clr_en  = 1'b1;
                    state_d = S_IDLE;
                end else if (op_in == OP_NOP) begin
                    adv_en  = 1'b1;
                    state_d = S_FETCH;
                end else if (op_in == OP_REPEAT) begin
                    if (rep_n == '0 || rep_l == '0) begin
                        // Skip: the skip target may not pass the enclosing loop end
                        if (ovf || (!stk_empty && sum > SUM_W'(top_end))) begin
                            state_d = S_ERROR;
                        end else begin
                            adv_en  = 1'b1;
                            adv_a   = sum[ADDR_W-1:0];
                            state_d = S_FETCH;
                        end
                    end else if (stk_full || ovf ||
                                 (!stk_empty && sum >= SUM_W'(top_end))) begin
                        state_d = S_ERROR;
                    end else begin
                        push_en = 1'b1;
                        pc_d    = pc + 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (op_in <= OP_LAST) begin
                    latch_en = 1'b1;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    adv_en  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // advance(a): loop back / pop when a lands on the innermost body end
        if (adv_en) begin
            if (!stk_empty && adv_a == top_end) begin
                if (top_rem != '0) begin
                    dec_en = 1'b1;
                    pc_d   = top_start;
                end else begin
                    pop_en = 1'b1;
                    pc_d   = adv_a + 1'b1;
                end
            end else begin
                pc_d = adv_a + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            sp         <= '0;
            op_q       <= '0;
            operands_q <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                stk_start[i] <= '0;
                stk_end[i]   <= '0;
                stk_rem[i]   <= '0;
            end
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            done_q <= done_d;
            if (latch_en) begin
                op_q       <= op_in;
                operands_q <= inst_rdata[INST_W-OP_W-1:0];
            end
            if (clr_en) begin
                sp <= '0;
            end else if (push_en) begin
                stk_start[push_idx] <= pc + 1'b1;
                stk_end[push_idx]   <= sum[ADDR_W-1:0];
                stk_rem[push_idx]   <= rep_n - 1'b1;
                sp                  <= sp + 1'b1;
            end else if (pop_en) begin
                sp <= sp - 1'b1;
            end else if (dec_en) begin
                stk_rem[top_idx] <= top_rem - 1'b1;
            end
        end
    end

    assign inst_rd_en     = (state == S_FETCH);
    assign inst_addr      = pc;
    assign issue_valid    = (state == S_ISSUE);
    assign issue_opcode   = op_q;
    assign issue_operands = operands_q;
    assign busy           = (state == S_FETCH) || (state == S_DECODE) || (state == S_ISSUE);
    assign done           = done_q;
    assign error          = (state == S_ERROR);
    assign loop_level     = sp;
    assign state_dbg      = state;

endmodule

// File: tb/tb_inst_sequencer.sv
module tb_inst_sequencer;

    localparam int INST_W = 32;
    localparam int ADDR_W = 6;
    localparam int OP_W   = 5;
    localparam int LVL_W  = 3;
    localparam int EW     = LVL_W + INST_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   start = 1'b0;
    logic [ADDR_W-1:0]      start_addr = '0;
    logic                   inst_rd_en;
    logic [ADDR_W-1:0]      inst_addr;
    logic [INST_W-1:0]      inst_rdata = '0;
    logic                   issue_valid;
    logic                   issue_ready = 1'b1;
    logic [OP_W-1:0]        issue_opcode;
    logic [INST_W-OP_W-1:0] issue_operands;
    logic                   busy, done, error;
    logic [LVL_W-1:0]       loop_level;
    logic [2:0]             state_dbg;

    inst_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .inst_rd_en(inst_rd_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_operands(issue_operands),
        .busy(busy), .done(done), .error(error),
        .loop_level(loop_level), .state_dbg(state_dbg)
    );

    // Synchronous instruction memory model
    logic [INST_W-1:0] mem [0:63];
    always @(posedge clk) if (inst_rd_en) inst_rdata <= mem[inst_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int n_cmp = 0, n_bad = 0;
    int n_issue, n_done, n_fetch, n_stall, max_lvl, first_valid_cyc, start_cyc;
    bit prev_stall = 1'b0;
    logic [INST_W-1:0] prev_word;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [INST_W-1:0] ins(input int op, input int ops);
        return {5'(op), 27'(ops)};
    endfunction

    function automatic logic [INST_W-1:0] rep(input int n, input int l);
        return {5'd2, 5'd0, 6'(l), 16'(n)};
    endfunction

    function automatic logic [EW-1:0] ex(input int lvl, input int op, input int ops);
        return {3'(lvl), ins(op, ops)};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {31'd0, issue_valid, issue_opcode, issue_operands},
                      {31'd0, 1'b1, prev_word});
            if (issue_valid && issue_ready) begin
                n_issue++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL issue_unexpected: got op %0d operands 0x%0h expected none",
                             issue_opcode, issue_operands);
                end else begin
                    check("issue", {29'd0, loop_level, issue_opcode, issue_operands},
                          {29'd0, exp_q.pop_front()});
                end
            end
            if (issue_valid && !issue_ready) n_stall++;
            if (issue_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (done) begin
                n_done++;
                check("busy_low_with_done", {63'd0, busy}, 64'd0);
            end
            if (inst_rd_en) n_fetch++;
            if (int'(loop_level) > max_lvl) max_lvl = int'(loop_level);
            prev_stall = issue_valid && !issue_ready;
            prev_word  = {issue_opcode, issue_operands};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = ins(0, 0);
    endtask

    task automatic do_start(input int addr);
        @(posedge clk); #1;
        n_issue = 0; n_done = 0; n_fetch = 0; n_stall = 0; max_lvl = 0;
        first_valid_cyc = -1;
        start_addr = ADDR_W'(addr);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name, input int max_cyc);
        int k;
        k = 0;
        while (!(done || error) && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (!(done || error)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no done/error expected end within %0d cycles", name, max_cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int k;
        k = 0;
        while (!issue_valid && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        if (!issue_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_valid_timeout: got issue_valid=0 expected 1", name);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, {39'd0, inst_rd_en, inst_addr, issue_valid, issue_opcode, busy, done,
                     error, loop_level, state_dbg}, 64'd0);
        check({name, "_operands"}, {37'd0, issue_operands}, 64'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_n = 1'b1;

        // 1. straight program
        clear_mem();
        mem[0] = ins(1, 0); mem[1] = ins(3, 'h123); mem[2] = ins(4, 'h45); mem[3] = ins(0, 0);
        exp_q.push_back(ex(0, 3, 'h123));
        exp_q.push_back(ex(0, 4, 'h45));
        do_start(0);
        wait_end("t1", 100);
        check("t1_queue_empty", 64'(exp_q.size()), 0);
        check("t1_issues", 64'(n_issue), 2);
        check("t1_done_pulses", 64'(n_done), 1);
        check("t1_first_valid_latency", 64'(first_valid_cyc - start_cyc), 5);

        // 2. backpressure
        clear_mem();
        mem[0] = ins(3, 'hABCDE); mem[1] = ins(0, 0);
        exp_q.push_back(ex(0, 3, 'hABCDE));
        issue_ready = 1'b0;
        do_start(0);
        wait_valid("t2", 20);
        repeat (5) @(posedge clk);
        #1 issue_ready = 1'b1;
        wait_end("t2", 100);
        check("t2_issues", 64'(n_issue), 1);
        check("t2_fetches", 64'(n_fetch), 2);
        check("t2_stall_cycles", 64'(n_stall), 5);
        check("t2_queue_empty", 64'(exp_q.size()), 0);

        // 3. single loop
        clear_mem();
        mem[10] = rep(3, 2); mem[11] = ins(3, 'h11); mem[12] = ins(4, 'h22); mem[13] = ins(0, 0);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ex(1, 3, 'h11));
            exp_q.push_back(ex(1, 4, 'h22));
        end
        do_start(10);
        wait_end("t3", 200);
        check("t3_issues", 64'(n_issue), 6);
        check("t3_queue_empty", 64'(exp_q.size()), 0);
        check("t3_max_level", 64'(max_lvl), 1);
        check("t3_level_after", 64'(loop_level), 0);
        check("t3_done_pulses", 64'(n_done), 1);

        // 4. nested loop
        clear_mem();
        mem[0] = rep(2, 3); mem[1] = rep(3, 1); mem[2] = ins(3, 'h31);
        mem[3] = ins(4, 'h41); mem[4] = ins(0, 0);
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back(ex(2, 3, 'h31));
            exp_q.push_back(ex(1, 4, 'h41));
        end
        do_start(0);
        wait_end("t4", 300);
        check("t4_issues", 64'(n_issue), 8);
        check("t4_queue_empty", 64'(exp_q.size()), 0);
        check("t4_max_level", 64'(max_lvl), 2);
        check("t4_level_after", 64'(loop_level), 0);
        check("t4_done_pulses", 64'(n_done), 1);

        // 5a. zero-count repeat skips its body
        clear_mem();
        mem[20] = rep(0, 2); mem[21] = ins(3, 1); mem[22] = ins(3, 2); mem[23] = ins(0, 0);
        do_start(20);
        wait_end("t5_skip", 100);
        check("t5_skip_issues", 64'(n_issue), 0);
        check("t5_skip_done", 64'(n_done), 1);
        check("t5_skip_no_error", 64'(error), 0);

        // 5b. highest legal opcode issues
        mem[40] = ins(10, 'h55); mem[41] = ins(0, 0);
        exp_q.push_back(ex(0, 10, 'h55));
        do_start(40);
        wait_end("t5_op10", 100);
        check("t5_op10_issues", 64'(n_issue), 1);

        // 5c. illegal opcodes 11 and 15
        for (int k = 0; k < 2; k++) begin
            mem[30] = ins((k == 0) ? 11 : 15, 'h7);
            do_start(30);
            wait_end("t5_badop", 100);
            check("t5_badop_error", {61'd0, error, busy, issue_valid}, {61'd0, 3'b100});
            check("t5_badop_state", 64'(state_dbg), 4);
            check("t5_badop_issues", 64'(n_issue), 0);
        end

        // 5d. nesting overflow on the fifth REPEAT
        clear_mem();
        mem[0] = rep(2, 10); mem[1] = rep(2, 8); mem[2] = rep(2, 6);
        mem[3] = rep(2, 4);  mem[4] = rep(2, 2);
        do_start(0);
        wait_end("t5_nest", 100);
        check("t5_nest_error", 64'(error), 1);
        check("t5_nest_level", 64'(loop_level), 4);
        check("t5_nest_issues", 64'(n_issue), 0);

        // 5e. start leaves ERROR
        mem[50] = ins(0, 0);
        do_start(50);
        check("t5_error_cleared", 64'(error), 0);
        wait_end("t5_restart", 100);
        check("t5_restart_done", 64'(n_done), 1);

        // 6. reset in the middle of a stalled issue
        clear_mem();
        mem[0] = ins(3, 'h66); mem[1] = ins(0, 0);
        issue_ready = 1'b0;
        do_start(0);
        wait_valid("t6", 20);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("t6_after_reset");
        rst_n = 1'b1;
        issue_ready = 1'b1;
        mem[40] = ins(5, 'h77); mem[41] = ins(0, 0);
        exp_q.push_back(ex(0, 5, 'h77));
        do_start(40);
        wait_end("t6_rerun", 100);
        check("t6_issues", 64'(n_issue), 1);
        check("t6_queue_empty", 64'(exp_q.size()), 0);
        check("t6_done_pulses", 64'(n_done), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
Parametrised instruction fetch/decode/issue sequencer for the NN accelerator. It reads 32-bit instructions from the synchronous instruction memory and interprets HALT, NOP and REPEAT internally, with a hardware loop stack for nested repeats. It issues execution opcodes (MATMUL..MAT_UPDATE) to the NU array over a valid/ready handshake.

Parameters:
INST_W, 32, instruction word width
ADDR_W, 6, instruction address width (64-deep instruction memory)
OP_W, 5, opcode field width, inst[INST_W-1 -: OP_W]; codes follow instruction_type order (HALT=0 .. MAT_UPDATE=10)
LOOP_DEPTH, 4, maximum REPEAT nesting levels
CNT_W, 16, REPEAT count field, inst[CNT_W-1:0]
LEN_W, 6, REPEAT body-length field, inst[CNT_W+LEN_W-1:CNT_W]

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin execution at start_addr; honoured only in IDLE or ERROR
start_addr  in  ADDR_W  first instruction address
inst_rd_en  out  1  instruction memory read strobe
inst_addr  out  ADDR_W  instruction memory address
inst_rdata  in  INST_W  read data, valid the cycle after inst_rd_en
issue_valid  out  1  execution instruction available
issue_ready  in  1  NU array accepts instruction
issue_opcode  out  OP_W  opcode being issued
issue_operands  out  INST_W-OP_W  remaining instruction bits
busy  out  1  high in FETCH, DECODE, ISSUE
done  out  1  one-cycle pulse on HALT
error  out  1  high while in ERROR
loop_level  out  $clog2(LOOP_DEPTH+1)  current stack occupancy

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; pc, stack pointer, issue registers and all outputs cleared to 0. Reset applies from any state, including mid-handshake; issue_valid is 0 the cycle after.
- IDLE: on start, pc<=start_addr and go to FETCH. ERROR behaves the same on start and clears error.
- FETCH: inst_rd_en=1, inst_addr=pc; next state DECODE.
- DECODE: decode inst_rdata.
  - HALT: done=1 for one cycle; clear the stack; go to IDLE. Pending loops are abandoned.
  - NOP: advance(pc); go to FETCH.
  - Opcode 3..10: latch opcode and operands into the issue registers; go to ISSUE.
  - Opcode >10: go to ERROR; nothing is issued.
  - REPEAT (N=count, L=len):
    - If N==0 or L==0: advance(pc+L), which skips the body.
    - Otherwise push {start=pc+1, end=pc+L, rem=N-1}; pc<=pc+1; go to FETCH.
    - The body executes N times in total.
- ISSUE: issue_valid=1. Opcode and operands stay stable while issue_ready=0. On valid&&ready: advance(pc); go to FETCH; issue_valid is 0 the next cycle.
- advance(a): if the stack is non-empty and a==top.end:
  - rem!=0: rem<=rem-1, pc<=top.start.
  - rem==0: pop, pc<=a+1.
  - Otherwise: pc<=a+1, modulo 2^ADDR_W.
- REPEAT error conditions (go to ERROR, stack unchanged):
  - Push with stack full (LOOP_DEPTH entries).
  - pc+L > 2^ADDR_W-1.
  - Push while the stack is non-empty and pc+L >= top.end (inner end must be strictly below outer end).
  - Skip while the stack is non-empty and pc+L > top.end.
- Latency: start at cycle T gives FETCH at T+1, DECODE at T+2, issue_valid at T+3. Each NOP or REPEAT costs 2 cycles. Each issued instruction costs 3 cycles with ready held high.
- ERROR: error=1, busy=0, issue_valid=0. Held until start or reset.
- start outside IDLE/ERROR is ignored.

Test Plan:
1. Straight program: mem[0..3]={NOP, MATMUL ops=0x123, ACCMOV, HALT}; start_addr=0, issue_ready=1. Required: issues opcode 3 (operands 0x123), then opcode 4, then one done pulse; busy falls with done; first issue_valid 5 cycles after start.
2. Backpressure: ready=0 for 5 cycles during MATMUL issue. Required: issue_valid held, opcode and operands unchanged, exactly one handshake, no refetch.
3. Single loop: mem={REPEAT N=3 L=2, MATMUL, ACCMOV, HALT}. Required: 6 issues alternating 3,4,3,4,3,4; loop_level 1 during body, 0 after; done.
4. Nested loop: mem={REPEAT N=2 L=3, REPEAT N=3 L=1, MATMUL, ACCMOV, HALT}. Required: MATMUL×3, ACCMOV, MATMUL×3, ACCMOV; loop_level peaks at 2; done.
5. Skip and errors:
   - REPEAT N=0 L=2 skips two MATMULs; HALT follows with zero issues.
   - Opcode 15 raises error with no issue.
   - 5 nested REPEATs with LOOP_DEPTH=4 raise error on the fifth.
   - start clears error.
6. Reset mid-ISSUE with ready=0: rst_n low for one edge. Required: all outputs 0 and IDLE next cycle; a subsequent start runs cleanly from start_addr.
